// File: rtl/instr_fetch.sv
// Instruction fetch stage: program-loadable 256x32 word memory feeding a registered instruction to the ALU stage.
// Latency: one cycle from start (or any accepted fetch) to instruction/instr_valid.
// Backpressure: stall freezes every register, and a jump requested under stall is dropped; prog_we is accepted only in IDLE/HALT.
//
// Ports:
//   clk, reset          - single rising-edge clock; asynchronous active-low reset
//   prog_we/addr/data   - program-load write port into the instruction memory
//   start               - IDLE -> FETCH, or HALT -> IDLE (pc cleared)
//   stall               - downstream not ready; hold everything while in FETCH
//   jump_en/jump_addr   - redirect the current fetch to jump_addr
//   instruction         - registered instruction word (zero when not valid)
//   instr_valid         - instruction holds a valid, non-halt word
//   pc                  - address of the next word to fetch
//   halted, state       - HALT indication and raw state (IDLE=00, FETCH=01, HALT=10)

module instr_fetch #(
    parameter logic [5:0] HALT_OP   = 6'b111111,
    parameter int         MEM_DEPTH = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        prog_we,
    input  logic [7:0]  prog_addr,
    input  logic [31:0] prog_data,
    input  logic        start,
    input  logic        stall,
    input  logic        jump_en,
    input  logic [7:0]  jump_addr,
    output logic [31:0] instruction,
    output logic        instr_valid,
    output logic [7:0]  pc,
    output logic        halted,
    output logic [1:0]  state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_FETCH = 2'b01,
        S_HALT  = 2'b10,
        S_BAD   = 2'b11
    } state_t;

    // ------------------------------------------------------------------
    // Registered state and outputs
    // ------------------------------------------------------------------
    state_t      state_q;
    logic [7:0]  pc_q;
    logic [31:0] instr_q;
    logic        valid_q;
    logic        halted_q;

    // ------------------------------------------------------------------
    // Instruction memory: synchronous write, combinational read.
    // Deliberately outside the reset domain so a reset keeps the program.
    // ------------------------------------------------------------------
    logic [31:0] mem [MEM_DEPTH];

    logic        prog_ok;

    // Loading while fetching would race the read path, so writes are only
    // honoured when the fetch engine is parked.
    assign prog_ok = prog_we && ((state_q == S_IDLE) || (state_q == S_HALT));

    always_ff @(posedge clk) begin
        if (prog_ok) begin
            mem[prog_addr] <= prog_data;
        end
    end

    // ------------------------------------------------------------------
    // Fetch decode: which address is read this cycle and whether the
    // result is committed on the coming edge.
    // ------------------------------------------------------------------
    logic [7:0]  fetch_addr_d;
    logic        fetch_go_d;
    logic [31:0] fetch_word;
    logic        fetch_is_halt;
    logic [7:0]  pc_next_d;

    always_comb begin
        fetch_addr_d = pc_q;
        fetch_go_d   = 1'b0;
        case (state_q)
            // A simultaneous program write wins over start.
            S_IDLE:  fetch_go_d = start && !prog_we;
            // Stall beats jump: the redirect is simply lost.
            S_FETCH: begin
                fetch_go_d = !stall;
                if (jump_en) begin
                    fetch_addr_d = jump_addr;
                end
            end
            default: fetch_go_d = 1'b0;
        endcase
    end

    assign fetch_word    = mem[fetch_addr_d];
    assign fetch_is_halt = (fetch_word[31:26] == HALT_OP);
    // 8-bit modulo increment: 255 wraps to 0 with no side effect.
    assign pc_next_d     = fetch_addr_d + 8'd1;

    // ------------------------------------------------------------------
    // Fetch FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            pc_q     <= 8'd0;
            instr_q  <= 32'd0;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_FETCH: begin
                    if (fetch_go_d) begin
                        if (fetch_is_halt) begin
                            // pc parks on the halt word itself so software
                            // can see where execution stopped.
                            instr_q  <= 32'd0;
                            valid_q  <= 1'b0;
                            pc_q     <= fetch_addr_d;
                            halted_q <= 1'b1;
                            state_q  <= S_HALT;
                        end else begin
                            instr_q  <= fetch_word;
                            valid_q  <= 1'b1;
                            pc_q     <= pc_next_d;
                            state_q  <= S_FETCH;
                        end
                    end
                end
                S_HALT: begin
                    // instruction/instr_valid are already zero here.
                    if (start) begin
                        pc_q     <= 8'd0;
                        halted_q <= 1'b0;
                        state_q  <= S_IDLE;
                    end
                end
                default: begin
                    // Unreachable encoding: recover to a clean IDLE.
                    state_q  <= S_IDLE;
                    pc_q     <= 8'd0;
                    instr_q  <= 32'd0;
                    valid_q  <= 1'b0;
                    halted_q <= 1'b0;
                end
            endcase
        end
    end

    assign instruction = instr_q;
    assign instr_valid = valid_q;
    assign pc          = pc_q;
    assign halted      = halted_q;
    assign state       = state_q;

endmodule

// File: tb/tb_instr_fetch.sv
`timescale 1ns/1ps
module tb_instr_fetch;

    localparam logic [5:0] HALT_OP = 6'b111111;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        prog_we = 1'b0;
    logic [7:0]  prog_addr = 8'd0;
    logic [31:0] prog_data = 32'd0;
    logic        start = 1'b0;
    logic        stall = 1'b0;
    logic        jump_en = 1'b0;
    logic [7:0]  jump_addr = 8'd0;
    logic [31:0] instruction;
    logic        instr_valid;
    logic [7:0]  pc;
    logic        halted;
    logic [1:0]  state;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    instr_fetch #(.HALT_OP(HALT_OP), .MEM_DEPTH(256)) dut (
        .clk(clk), .reset(reset), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_data(prog_data), .start(start), .stall(stall), .jump_en(jump_en),
        .jump_addr(jump_addr), .instruction(instruction), .instr_valid(instr_valid),
        .pc(pc), .halted(halted), .state(state)
    );

    // Behavioural reference: memory image plus architectural outputs.
    logic [31:0] mem_m [256];
    logic [1:0]  m_state;
    logic [7:0]  m_pc;
    logic [31:0] m_instr;
    logic        m_valid;
    logic        m_halted;

    function automatic logic [31:0] rnd_word();
        logic [31:0] w;
        w = $urandom;
        if (w[31:26] == HALT_OP) w[31:26] = 6'd0;
        return w;
    endfunction

    function automatic logic [31:0] halt_word();
        logic [31:0] w;
        w = $urandom;
        w[31:26] = HALT_OP;
        return w;
    endfunction

    function automatic logic [43:0] dut_vec();
        return {instruction, instr_valid, pc, halted, state};
    endfunction

    function automatic logic [43:0] mdl_vec();
        return {m_instr, m_valid, m_pc, m_halted, m_state};
    endfunction

    task automatic model_reset();
        m_state = 2'b00; m_pc = 8'd0; m_instr = 32'd0; m_valid = 1'b0; m_halted = 1'b0;
    endtask

    task automatic model_fetch(input logic [7:0] a);
        logic [31:0] w;
        w = mem_m[a];
        if (w[31:26] == HALT_OP) begin
            m_instr = 32'd0; m_valid = 1'b0; m_pc = a; m_halted = 1'b1; m_state = 2'b10;
        end else begin
            m_instr = w; m_valid = 1'b1; m_pc = a + 8'd1; m_state = 2'b01;
        end
    endtask

    task automatic model_step(input logic we, input logic [7:0] wa, input logic [31:0] wd,
                              input logic st, input logic stl, input logic je, input logic [7:0] ja);
        case (m_state)
            2'b00: begin
                if (we) mem_m[wa] = wd;
                else if (st) model_fetch(m_pc);
            end
            2'b01: if (!stl) model_fetch(je ? ja : m_pc);
            2'b10: begin
                if (we) mem_m[wa] = wd;
                if (st) begin m_pc = 8'd0; m_halted = 1'b0; m_state = 2'b00; end
            end
            default: model_reset();
        endcase
    endtask

    // One clock: drive on the falling edge, sample 1ns after the rising edge.
    task automatic tick(input logic we, input logic [7:0] wa, input logic [31:0] wd,
                        input logic st, input logic stl, input logic je, input logic [7:0] ja);
        @(negedge clk);
        prog_we = we; prog_addr = wa; prog_data = wd;
        start = st; stall = stl; jump_en = je; jump_addr = ja;
        model_step(we, wa, wd, st, stl, je, ja);
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        prog_we = 1'b0; prog_addr = 8'd0; prog_data = 32'd0;
        start = 1'b0; stall = 1'b0; jump_en = 1'b0; jump_addr = 8'd0;
    endtask

    task automatic test_reset();
        idle_inputs();
        model_reset();
        #1 reset = 1'b0;
        #1;
        checks++;
        if (dut_vec() !== 44'd0) begin
            errors++; $display("FAIL reset_immediate: got %h expected 0", dut_vec());
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (dut_vec() !== 44'd0) begin
            errors++; $display("FAIL reset_held: got %h expected 0", dut_vec());
        end
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 256; i++) tick(1'b1, 8'(i), rnd_word(), 1'b0, 1'b0, 1'b0, 8'd0);
        repeat (3) tick(1'b0, 8'd0, 32'd0, 1'b0, 1'b0, 1'b0, 8'd0);
        checks++;
        if (dut_vec() !== mdl_vec() || state !== 2'b00) begin
            errors++; $display("FAIL idle_after_reset: got %h expected %h", dut_vec(), mdl_vec());
        end
    endtask

    task automatic test_halt_program();
        tick(1'b1, 8'd0, 32'h0000_0005, 1'b0, 1'b0, 1'b0, 8'd0);
        tick(1'b1, 8'd1, 32'h0400_0000, 1'b0, 1'b0, 1'b0, 8'd0);
        tick(1'b1, 8'd2, 32'hFC00_0000, 1'b0, 1'b0, 1'b0, 8'd0);
        tick(1'b0, 8'd0, 32'd0, 1'b1, 1'b0, 1'b0, 8'd0);
        checks++;
        if (instruction !== 32'h0000_0005 || pc !== 8'd1 || instr_valid !== 1'b1 || state !== 2'b01) begin
            errors++; $display("FAIL prog_word0: got instr=%h pc=%h vld=%b st=%b expected 00000005/01/1/01",
                               instruction, pc, instr_valid, state);
        end
        tick(1'b0, 8'd0, 32'd0, 1'b0, 1'b0, 1'b0, 8'd0);
        checks++;
        if (instruction !== 32'h0400_0000 || pc !== 8'd2 || instr_valid !== 1'b1) begin
            errors++; $display("FAIL prog_word1: got instr=%h pc=%h vld=%b expected 04000000/02/1",
                               instruction, pc, instr_valid);
        end
        tick(1'b0, 8'd0, 32'd0, 1'b0, 1'b0, 1'b0, 8'd0);
        checks++;
        if (instruction !== 32'd0 || instr_valid !== 1'b0 || halted !== 1'b1 || pc !== 8'd2 || state !== 2'b10) begin
            errors++; $display("FAIL prog_halt: got instr=%h vld=%b halted=%b pc=%h st=%b expected 0/0/1/02/10",
                               instruction, instr_valid, halted, pc, state);
        end
        // HALT ignores stall and jump.
        tick(1'b0, 8'd0, 32'd0, 1'b0, 1'b1, 1'b1, 8'h33);
        checks++;
        if (dut_vec() !== {32'd0, 1'b0, 8'd2, 1'b1, 2'b10}) begin
            errors++; $display("FAIL halt_hold: got %h expected %h", dut_vec(), {32'd0, 1'b0, 8'd2, 1'b1, 2'b10});
        end
        tick(1'b0, 8'd0, 32'd0, 1'b1, 1'b0, 1'b0, 8'd0);
        checks++;
        if (dut_vec() !== {32'd0, 1'b0, 8'd0, 1'b0, 2'b00} || dut_vec() !== mdl_vec()) begin
            errors++; $display("FAIL halt_to_idle: got %h expected %h", dut_vec(), mdl_vec());
        end
    endtask

    task automatic test_stall();
        logic [31:0] w [5];
        for (int i = 0; i < 4; i++) begin
            w[i] = rnd_word();
            tick(1'b1, 8'(i), w[i], 1'b0, 1'b0, 1'b0, 8'd0);
        end
        w[4] = halt_word();
        tick(1'b1, 8'd4, w[4], 1'b0, 1'b0, 1'b0, 8'd0);
        tick(1'b0, 8'd0, 32'd0, 1'b1, 1'b0, 1'b0, 8'd0);
        tick(1'b0, 8'd0, 32'd0, 1'b0, 1'b0, 1'b0, 8'd0);
        for (int k = 0; k < 3; k++) begin
            tick(1'b0, 8'd0, 32'd0, 1'b0, 1'b1, 1'b0, 8'd0);
            checks++;
            if (instruction !== w[1] || pc !== 8'd2 || instr_valid !== 1'b1 || state !== 2'b01) begin
                errors++; $display("FAIL stall_freeze%0d: got instr=%h pc=%h expected %h/02", k, instruction, pc, w[1]);
            end
        end
        for (int i = 2; i < 4; i++) begin
            tick(1'b0, 8'd0, 32'd0, 1'b0, 1'b0, 1'b0, 8'd0);
            checks++;
            if (instruction !== w[i] || pc !== 8'(i + 1) || instr_valid !== 1'b1) begin
                errors++; $display("FAIL stall_resume%0d: got instr=%h pc=%h expected %h/%h", i, instruction, pc, w[i], 8'(i + 1));
            end
        end
        tick(1'b0, 8'd0, 32'd0, 1'b0, 1'b0, 1'b0, 8'd0);
        checks++;
        if (halted !== 1'b1 || pc !== 8'd4 || instr_valid !== 1'b0) begin
            errors++; $display("FAIL stall_end_halt: got halted=%b pc=%h vld=%b expected 1/04/0", halted, pc, instr_valid);
        end
        tick(1'b0, 8'd0, 32'd0, 1'b1, 1'b0, 1'b0, 8'd0);
    endtask

    task automatic test_jump();
        logic [31:0] a;
        a = rnd_word();
        tick(1'b1, 8'h80, a, 1'b0, 1'b0, 1'b0, 8'd0);
        tick(1'b1, 8'h40, halt_word(), 1'b0, 1'b0, 1'b0, 8'd0);
        tick(1'b0, 8'd0, 32'd0, 1'b1, 1'b0, 1'b0, 8'd0);
        tick(1'b0, 8'd0, 32'd0, 1'b0, 1'b0, 1'b0, 8'd0);
        tick(1'b0, 8'd0, 32'd0, 1'b0, 1'b0, 1'b0, 8'd0);
        checks++;
        if (pc !== 8'd3 || dut_vec() !== mdl_vec()) begin
            errors++; $display("FAIL jump_setup: got %h expected %h", dut_vec(), mdl_vec());
        end
        tick(1'b0, 8'd0, 32'd0, 1'b0, 1'b0, 1'b1, 8'h80);
        checks++;
        if (instruction !== a || pc !== 8'h81 || instr_valid !== 1'b1) begin
            errors++; $display("FAIL jump_redirect: got instr=%h pc=%h expected %h/81", instruction, pc, a);
        end
        tick(1'b0, 8'd0, 32'd0, 1'b0, 1'b1, 1'b1, 8'h40);
        checks++;
        if (instruction !== a || pc !== 8'h81 || state !== 2'b01) begin
            errors++; $display("FAIL jump_under_stall: got instr=%h pc=%h st=%b expected %h/81/01", instruction, pc, state, a);
        end
        tick(1'b0, 8'd0, 32'd0, 1'b0, 1'b0, 1'b1, 8'h40);
        checks++;
        if (halted !== 1'b1 || pc !== 8'h40 || instruction !== 32'd0 || state !== 2'b10) begin
            errors++; $display("FAIL jump_to_halt: got halted=%b pc=%h instr=%h expected 1/40/0", halted, pc, instruction);
        end
        tick(1'b0, 8'd0, 32'd0, 1'b1, 1'b0, 1'b0, 8'd0);
    endtask

    task automatic test_wrap();
        logic [31:0] w0, c;
        w0 = rnd_word(); c = rnd_word();
        tick(1'b1, 8'h00, w0, 1'b0, 1'b0, 1'b0, 8'd0);
        tick(1'b1, 8'hFF, c, 1'b0, 1'b0, 1'b0, 8'd0);
        tick(1'b1, 8'h01, halt_word(), 1'b0, 1'b0, 1'b0, 8'd0);
        tick(1'b0, 8'd0, 32'd0, 1'b1, 1'b0, 1'b0, 8'd0);
        tick(1'b0, 8'd0, 32'd0, 1'b0, 1'b0, 1'b1, 8'hFF);
        checks++;
        if (instruction !== c || pc !== 8'h00 || instr_valid !== 1'b1) begin
            errors++; $display("FAIL wrap_pc: got instr=%h pc=%h expected %h/00", instruction, pc, c);
        end
        tick(1'b0, 8'd0, 32'd0, 1'b0, 1'b0, 1'b0, 8'd0);
        checks++;
        if (instruction !== w0 || pc !== 8'h01) begin
            errors++; $display("FAIL wrap_next: got instr=%h pc=%h expected %h/01", instruction, pc, w0);
        end
        tick(1'b0, 8'd0, 32'd0, 1'b0, 1'b0, 1'b0, 8'd0);
        tick(1'b0, 8'd0, 32'd0, 1'b1, 1'b0, 1'b0, 8'd0);
        // Halt word at address 0: halts with pc parked on 0.
        tick(1'b1, 8'h00, halt_word(), 1'b0, 1'b0, 1'b0, 8'd0);
        tick(1'b0, 8'd0, 32'd0, 1'b1, 1'b0, 1'b0, 8'd0);
        checks++;
        if (halted !== 1'b1 || pc !== 8'h00 || instr_valid !== 1'b0 || state !== 2'b10) begin
            errors++; $display("FAIL halt_at_zero: got halted=%b pc=%h vld=%b st=%b expected 1/00/0/10", halted, pc, instr_valid, state);
        end
        tick(1'b0, 8'd0, 32'd0, 1'b1, 1'b0, 1'b0, 8'd0);
    endtask

    task automatic test_async_reset();
        logic [31:0] x [3];
        logic [31:0] y;
        for (int i = 0; i < 3; i++) begin
            x[i] = rnd_word();
            tick(1'b1, 8'(i), x[i], 1'b0, 1'b0, 1'b0, 8'd0);
        end
        tick(1'b1, 8'd3, halt_word(), 1'b0, 1'b0, 1'b0, 8'd0);
        tick(1'b0, 8'd0, 32'd0, 1'b1, 1'b0, 1'b0, 8'd0);
        tick(1'b0, 8'd0, 32'd0, 1'b0, 1'b0, 1'b0, 8'd0);
        #2;
        idle_inputs();
        reset = 1'b0;
        model_reset();
        #1;
        checks++;
        if (dut_vec() !== 44'd0) begin
            errors++; $display("FAIL async_reset_clear: got %h expected 0", dut_vec());
        end
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        tick(1'b0, 8'd0, 32'd0, 1'b0, 1'b0, 1'b0, 8'd0);
        checks++;
        if (dut_vec() !== 44'd0) begin
            errors++; $display("FAIL reset_release_idle: got %h expected 0", dut_vec());
        end
        tick(1'b0, 8'd0, 32'd0, 1'b1, 1'b0, 1'b0, 8'd0);
        checks++;
        if (instruction !== x[0] || pc !== 8'd1) begin
            errors++; $display("FAIL mem_kept_over_reset: got instr=%h pc=%h expected %h/01", instruction, pc, x[0]);
        end
        // Write attempt while fetching must be dropped.
        tick(1'b1, 8'd2, ~x[2], 1'b0, 1'b0, 1'b0, 8'd0);
        tick(1'b0, 8'd0, 32'd0, 1'b0, 1'b0, 1'b0, 8'd0);
        checks++;
        if (instruction !== x[2] || pc !== 8'd3) begin
            errors++; $display("FAIL fetch_write_ignored: got instr=%h pc=%h expected %h/03", instruction, pc, x[2]);
        end
        tick(1'b0, 8'd0, 32'd0, 1'b0, 1'b0, 1'b0, 8'd0);
        tick(1'b0, 8'd0, 32'd0, 1'b1, 1'b0, 1'b0, 8'd0);
        y = rnd_word();
        tick(1'b1, 8'd0, y, 1'b1, 1'b0, 1'b0, 8'd0);
        checks++;
        if (state !== 2'b00 || instr_valid !== 1'b0 || pc !== 8'd0) begin
            errors++; $display("FAIL write_with_start: got st=%b vld=%b pc=%h expected 00/0/00", state, instr_valid, pc);
        end
        tick(1'b0, 8'd0, 32'd0, 1'b1, 1'b0, 1'b0, 8'd0);
        checks++;
        if (instruction !== y || pc !== 8'd1) begin
            errors++; $display("FAIL write_with_start_data: got instr=%h pc=%h expected %h/01", instruction, pc, y);
        end
        tick(1'b0, 8'd0, 32'd0, 1'b0, 1'b0, 1'b1, 8'd3);
        tick(1'b0, 8'd0, 32'd0, 1'b1, 1'b0, 1'b0, 8'd0);
    endtask

    task automatic test_random();
        logic [31:0] w;
        checks++;
        if (dut_vec() !== mdl_vec() || state !== 2'b00) begin
            errors++; $display("FAIL random_entry: got %h expected %h", dut_vec(), mdl_vec());
        end
        for (int i = 0; i < 256; i++) begin
            w = ($urandom_range(5) == 0) ? halt_word() : rnd_word();
            tick(1'b1, 8'(i), w, 1'b0, 1'b0, 1'b0, 8'd0);
        end
        for (int n = 0; n < 1500; n++) begin
            w = ($urandom_range(5) == 0) ? halt_word() : rnd_word();
            tick(($urandom_range(7) == 0), 8'($urandom), w, ($urandom_range(3) == 0),
                 ($urandom_range(3) == 0), ($urandom_range(4) == 0), 8'($urandom));
            checks++;
            if (dut_vec() !== mdl_vec() || state === 2'b11) begin
                errors++; $display("FAIL random_cycle%0d: got %h expected %h", n, dut_vec(), mdl_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_halt_program();
        test_stall();
        test_jump();
        test_wrap();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
